// File: rtl/lcd_timing_pkg.sv
// Shared constants for the LCD raster timing generator: 480x272 panel defaults,
// sync polarity encodings and a constant-evaluable ceil(log2) helper.
package lcd_timing_pkg;

  localparam int unsigned DEF_H_SYNC   = 41;
  localparam int unsigned DEF_H_BP     = 2;
  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FP     = 2;
  localparam int unsigned DEF_V_SYNC   = 10;
  localparam int unsigned DEF_V_BP     = 2;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FP     = 2;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // Bits needed to hold 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned rem;
    width = 0;
    rem   = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      width = width + 1;
      rem   = rem >> 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/lcd_timing_axis.sv
// One raster axis: position counter plus combinational sync/active/position
// decodes of the current count; WRAP flags the last position of the axis.
module lcd_timing_axis
  import lcd_timing_pkg::*;
#(
  parameter int unsigned SYNC_LEN = DEF_H_SYNC,
  parameter int unsigned BP       = DEF_H_BP,
  parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned FP       = DEF_H_FP,
  parameter logic        POL      = POL_ACTIVE_LOW,
  localparam int unsigned TOTAL   = SYNC_LEN + BP + ACTIVE + FP,
  localparam int unsigned W       = clog2(TOTAL)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ADV,
  output logic [W-1:0] COUNT,
  output logic         SYNC,
  output logic         ADE,
  output logic [W-1:0] POS,
  output logic         WRAP
);

  // Inclusive bounds keep every constant inside W bits even when FP is 0.
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LAST = W'(SYNC_LEN - 1);
  localparam logic [W-1:0] ACT_FIRST = W'(SYNC_LEN + BP);
  localparam logic [W-1:0] ACT_LAST  = W'(SYNC_LEN + BP + ACTIVE - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    WRAP    = (count_q == LAST);
    count_d = count_q;
    if (ADV) begin
      count_d = WRAP ? '0 : count_q + W'(1);
    end
    COUNT = count_q;
    SYNC  = (count_q <= SYNC_LAST) ? POL : ~POL;
    ADE   = (count_q >= ACT_FIRST) && (count_q <= ACT_LAST);
    POS   = ADE ? count_q - ACT_FIRST : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// TFT-LCD raster timing generator: H and V axis counters with every decoded
// output registered from the pre-increment position (one cycle of latency).
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter logic        HS_POL   = POL_ACTIVE_LOW,
  parameter logic        VS_POL   = POL_ACTIVE_LOW,
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
  localparam int unsigned HW      = clog2(H_TOTAL),
  localparam int unsigned VW      = clog2(V_TOTAL)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN,
  input  logic          BLANK,
  output logic [HW-1:0] H_COUNT,
  output logic [VW-1:0] V_COUNT,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          hDE,
  output logic          vDE,
  output logic          DE,
  output logic [HW-1:0] PIX_X,
  output logic [VW-1:0] PIX_Y,
  output logic          LINE_START,
  output logic          FRAME_START
);

  logic [HW-1:0] h_count, h_pos;
  logic [VW-1:0] v_count, v_pos;
  logic          h_sync, h_ade, h_wrap, v_adv;
  logic          v_sync, v_ade, v_wrap;

  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          hde_q, hde_d, vde_q, vde_d, de_q, de_d;
  logic [HW-1:0] pix_x_q, pix_x_d;
  logic [VW-1:0] pix_y_q, pix_y_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic          at_origin_q, at_origin_d;

  assign v_adv = EN & h_wrap;

  lcd_timing_axis #(
    .SYNC_LEN(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .POL(HS_POL)
  ) u_h_axis (
    .CLK(CLK), .RESET(RESET), .ADV(EN),
    .COUNT(h_count), .SYNC(h_sync), .ADE(h_ade), .POS(h_pos), .WRAP(h_wrap)
  );

  lcd_timing_axis #(
    .SYNC_LEN(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .POL(VS_POL)
  ) u_v_axis (
    .CLK(CLK), .RESET(RESET), .ADV(v_adv),
    .COUNT(v_count), .SYNC(v_sync), .ADE(v_ade), .POS(v_pos), .WRAP(v_wrap)
  );

  // at_origin tracks (H,V)==(0,0) from reset and the joint wrap, avoiding a
  // second full-width compare on the vertical count.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hde_d         = hde_q;
    vde_d         = vde_q;
    de_d          = de_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    at_origin_d   = at_origin_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (EN) begin
      hsync_d       = h_sync;
      vsync_d       = v_sync;
      hde_d         = h_ade;
      vde_d         = v_ade;
      de_d          = h_ade & v_ade & ~BLANK;
      pix_x_d       = h_pos;
      pix_y_d       = v_pos;
      line_start_d  = (h_count == '0);
      frame_start_d = at_origin_q;
      at_origin_d   = h_wrap & v_wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hde_q         <= 1'b0;
      vde_q         <= 1'b0;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      at_origin_q   <= 1'b1;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hde_q         <= hde_d;
      vde_q         <= vde_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      at_origin_q   <= at_origin_d;
    end
  end

  always_comb begin
    H_COUNT     = h_count;
    V_COUNT     = v_count;
    HSYNC       = hsync_q;
    VSYNC       = vsync_q;
    hDE         = hde_q;
    vDE         = vde_q;
    DE          = de_q;
    PIX_X       = pix_x_q;
    PIX_Y       = pix_y_q;
    LINE_START  = line_start_q;
    FRAME_START = frame_start_q;
  end

endmodule
